// File: rtl/pam_map_pkg.sv
// pam_map_pkg: shared types and helpers for the pam_map_lanes symbol mapper.
// Holds the frame state enum, the buffer sizing constant, the kept-byte
// counter, the Gray decoder and the saturating offset+index*step code law.
package pam_map_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Bit buffer depth, in input beats.
    localparam int BUF_BEATS   = 2;
    // Widest tkeep vector the kept-byte counter accepts.
    localparam int KEEP_MAX_W  = 64;
    // Widest symbol index the Gray decoder accepts.
    localparam int IDX_MAX_W   = 8;
    // Working width of the code law. Exact as long as CODE_W + IDX_W <= 32,
    // because offset + index*step < 2^(CODE_W+IDX_W) never overflows.
    localparam int CODE_CALC_W = 32;

    // Number of enabled bytes in a beat.
    function automatic int kept_bytes(input logic [KEEP_MAX_W-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            n += int'(keep[i]);
        end
        return n;
    endfunction

    // Reflected-binary Gray code to natural binary.
    function automatic logic [IDX_MAX_W-1:0] gray2bin(input logic [IDX_MAX_W-1:0] g);
        logic [IDX_MAX_W-1:0] b;
        b[IDX_MAX_W-1] = g[IDX_MAX_W-1];
        for (int i = IDX_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // offset + index*step, clamped to the largest code_w-bit code.
    function automatic logic [CODE_CALC_W-1:0] sat_code(
        input logic [CODE_CALC_W-1:0] offset,
        input logic [CODE_CALC_W-1:0] step,
        input logic [CODE_CALC_W-1:0] index,
        input int                     code_w
    );
        logic [CODE_CALC_W-1:0] wide;
        logic [CODE_CALC_W-1:0] lim;
        wide = offset + index * step;
        lim  = (CODE_CALC_W'(1) << code_w) - CODE_CALC_W'(1);
        return (wide > lim) ? lim : wide;
    endfunction

    // Out-of-range bits-per-symbol falls back to PAM2.
    function automatic logic [2:0] sane_bps(input logic [2:0] bps, input int max_bps);
        return ((bps == 3'd0) || (int'(bps) > max_bps)) ? 3'd1 : bps;
    endfunction

endpackage

// File: rtl/pam_map_lanes_if.sv
// pam_map_lanes_if: AXI-Stream input and PamMap2AddHead output bundle of the
// PAM mapper. The slave modport is the mapper side; master is the
// FIFO/add_frame_head side.
interface pam_map_lanes_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AD_CVER_WIDTH  = 12,
    parameter int LANES          = 2
);
    logic [AXI_DATA_WIDTH-1:0]       M_AXIS_tdata;
    logic [AXI_DATA_WIDTH/8-1:0]     M_AXIS_tkeep;
    logic                            M_AXIS_tlast;
    logic                            M_AXIS_tvalid;
    logic                            M_AXIS_tready;
    logic                            PamMap2AddHead_ready;
    logic                            PamMap2AddHead_valid;
    logic [LANES*AD_CVER_WIDTH-1:0]  PamMap2AddHead_data;
    logic                            PamMap2AddHead_last;

    modport master (
        output M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tvalid,
        output PamMap2AddHead_ready,
        input  M_AXIS_tready,
        input  PamMap2AddHead_valid, PamMap2AddHead_data, PamMap2AddHead_last
    );

    modport slave (
        input  M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tvalid,
        input  PamMap2AddHead_ready,
        output M_AXIS_tready,
        output PamMap2AddHead_valid, PamMap2AddHead_data, PamMap2AddHead_last
    );
endinterface

// File: rtl/pam_level_calc.sv
// pam_level_calc: combinational symbol index to DAC code for one lane,
// code = offset + idx*step saturated to the full-scale code.
module pam_level_calc
    import pam_map_pkg::*;
#(
    parameter int CODE_W = 12,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [CODE_W-1:0] offset,
    input  logic [CODE_W-1:0] step,
    output logic [CODE_W-1:0] code
);

    assign code = CODE_W'(sat_code(CODE_CALC_W'(offset), CODE_CALC_W'(step),
                                   CODE_CALC_W'(idx), CODE_W));

endmodule

// File: rtl/pam_map_lanes.sv
// pam_map_lanes: unpacks AXI-Stream bytes LSB-first into PAM2..PAM16 symbols
// and emits LANES DAC codes per output beat. Frame configuration is latched
// on the first accepted beat; tlast drains the bit buffer with zero padding
// and marks the final output beat.
// Build option: define PAM_MAP_GRAY_EN to Gray-decode each symbol group
// before the code law; otherwise groups are natural-binary indices.
module pam_map_lanes
    import pam_map_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AD_CVER_WIDTH  = 12,
    parameter int LANES          = 2,
    parameter int MAX_BPS        = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [2:0]               cfg_bps,
    input  logic [AD_CVER_WIDTH-1:0] cfg_offset,
    input  logic [AD_CVER_WIDTH-1:0] cfg_step,
    pam_map_lanes_if.slave           bus
);

    localparam int KEEP_W = AXI_DATA_WIDTH / 8;
    localparam int BUF_W  = BUF_BEATS * AXI_DATA_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int OUT_W  = LANES * AD_CVER_WIDTH;

    // Frame control
    state_e                   state_q, state_d;
    logic                     alive_q;
    logic [2:0]               bps_q;
    logic [AD_CVER_WIDTH-1:0] offset_q, step_q;

    // Bit buffer: valid bits sit at [fill_q-1:0], everything above is zero,
    // which is what provides the zero padding of the last group.
    logic [BUF_W-1:0]         bit_buf_q, bit_buf_d;
    logic [FILL_W-1:0]        fill_q, fill_d;

    // Output register stage
    logic                     vld_p1;
    logic [OUT_W-1:0]         data_p1;
    logic                     last_p1;

    logic                     tready;
    logic                     accept;
    logic [AXI_DATA_WIDTH-1:0] in_masked;
    logic [FILL_W-1:0]        in_bits;
    logic [FILL_W-1:0]        grp_bits;
    logic [FILL_W-1:0]        consumed;
    logic                     out_free;
    logic                     have_beat;
    logic                     load;
    logic                     last_d;
    logic [MAX_BPS-1:0]       idx_mask;
    logic [OUT_W-1:0]         codes_flat;

    assign tready   = alive_q && (fill_q <= FILL_W'(AXI_DATA_WIDTH)) && (state_q != FLUSH);
    assign accept   = bus.M_AXIS_tvalid && tready;
    assign grp_bits = FILL_W'(LANES * int'(bps_q));
    assign in_bits  = FILL_W'(kept_bytes(KEEP_MAX_W'(bus.M_AXIS_tkeep)) * 8);
    assign idx_mask = MAX_BPS'((32'd1 << bps_q) - 32'd1);

    // A beat is ready to map once a full group is buffered, or, while
    // flushing, whenever any bits remain (the tail gets zero padded).
    assign out_free  = !vld_p1 || bus.PamMap2AddHead_ready;
    assign have_beat = ((state_q == RUN) && (fill_q >= grp_bits)) ||
                       ((state_q == FLUSH) && (fill_q != '0));
    assign load      = out_free && have_beat;
    assign last_d    = (state_q == FLUSH) && (fill_q <= grp_bits);
    assign consumed  = load ? ((fill_q < grp_bits) ? fill_q : grp_bits) : '0;

    // Per-lane symbol extraction and code computation
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [MAX_BPS-1:0]       grp_raw;
        logic [MAX_BPS-1:0]       lane_idx;
        logic [AD_CVER_WIDTH-1:0] lane_code;

        assign grp_raw = MAX_BPS'(bit_buf_q >> (k * int'(bps_q))) & idx_mask;
`ifdef PAM_MAP_GRAY_EN
        assign lane_idx = MAX_BPS'(gray2bin(IDX_MAX_W'(grp_raw)));
`else
        assign lane_idx = grp_raw;
`endif

        pam_level_calc #(
            .CODE_W (AD_CVER_WIDTH),
            .IDX_W  (MAX_BPS)
        ) u_level_calc (
            .idx    (lane_idx),
            .offset (offset_q),
            .step   (step_q),
            .code   (lane_code)
        );

        assign codes_flat[k*AD_CVER_WIDTH +: AD_CVER_WIDTH] = lane_code;
    end

    // Mask disabled bytes, then shift out the consumed group and append the
    // incoming bytes directly above the bits that remain.
    always_comb begin
        in_masked = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            in_masked[b*8 +: 8] = bus.M_AXIS_tkeep[b] ? bus.M_AXIS_tdata[b*8 +: 8] : 8'h00;
        end
        bit_buf_d = bit_buf_q >> consumed;
        fill_d    = fill_q - consumed;
        if (accept) begin
            bit_buf_d = bit_buf_d | (BUF_W'(in_masked) << (fill_q - consumed));
            fill_d    = fill_d + in_bits;
        end
    end

    // Frame FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.M_AXIS_tlast ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept && bus.M_AXIS_tlast) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Leave on the handshake of the last beat, or at once when a
                // zero-keep tlast found nothing left to emit.
                if (vld_p1 && last_p1 && bus.PamMap2AddHead_ready) begin
                    state_d = IDLE;
                end else if ((fill_q == '0) && !(vld_p1 && last_p1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, frame configuration latch and bit buffer
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            alive_q   <= 1'b0;
            bps_q     <= 3'd1;
            offset_q  <= '0;
            step_q    <= '0;
            bit_buf_q <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= 1'b1;
            bit_buf_q <= bit_buf_d;
            fill_q    <= fill_d;
            if ((state_q == IDLE) && accept) begin
                bps_q    <= sane_bps(cfg_bps, MAX_BPS);
                offset_q <= cfg_offset;
                step_q   <= cfg_step;
            end
        end
    end

    // ---- stage p1: registered output beat, held while stalled ----
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= codes_flat;
            last_p1 <= last_d;
        end else if (bus.PamMap2AddHead_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.M_AXIS_tready        = tready;
    assign bus.PamMap2AddHead_valid = vld_p1;
    assign bus.PamMap2AddHead_data  = data_p1;
    assign bus.PamMap2AddHead_last  = last_p1;

endmodule

// File: tb/tb_pam_map_lanes.sv
// tb_pam_map_lanes: scoreboard bench for pam_map_lanes (2 lanes, 12-bit codes,
// 32-bit input). Stimulus pushes expected output beats; a monitor pops and
// compares on every output handshake and checks that stalled beats hold.
module tb_pam_map_lanes;

    localparam int AXW = 32;
    localparam int CW  = 12;
    localparam int LN  = 2;

    typedef struct packed {
        logic [LN*CW-1:0] data;
        logic             last;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst;
    logic [2:0] cfg_bps;
    logic [CW-1:0] cfg_offset;
    logic [CW-1:0] cfg_step;

    int   n_vec;
    int   n_err;
    int   ready_mode;
    exp_t exp_q[$];

    pam_map_lanes_if #(.AXI_DATA_WIDTH(AXW), .AD_CVER_WIDTH(CW), .LANES(LN)) bus ();

    pam_map_lanes #(
        .AXI_DATA_WIDTH (AXW),
        .AD_CVER_WIDTH  (CW),
        .LANES          (LN),
        .MAX_BPS        (4)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .cfg_bps    (cfg_bps),
        .cfg_offset (cfg_offset),
        .cfg_step   (cfg_step),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference code law for the backpressure model (4-bit symbols).
    function automatic logic [CW-1:0] ref_code(input logic [3:0] grp, input int off, input int stp);
        logic [3:0] idx;
        int v;
`ifdef PAM_MAP_GRAY_EN
        idx = grp ^ (grp >> 1) ^ (grp >> 2) ^ (grp >> 3);
`else
        idx = grp;
`endif
        v = off + int'(idx) * stp;
        if (v > 4095) v = 4095;
        return CW'(v);
    endfunction

    task automatic expect_beat(input logic [CW-1:0] l0, input logic [CW-1:0] l1, input logic last);
        exp_t e;
        e.data = {l1, l0};
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_tready"}, 32'(bus.M_AXIS_tready), 32'd0);
        check({name, "_valid"},  32'(bus.PamMap2AddHead_valid), 32'd0);
        check({name, "_data"},   32'(bus.PamMap2AddHead_data), 32'd0);
        check({name, "_last"},   32'(bus.PamMap2AddHead_last), 32'd0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int guard;
        guard = 0;
        bus.M_AXIS_tdata  = d;
        bus.M_AXIS_tkeep  = k;
        bus.M_AXIS_tlast  = l;
        bus.M_AXIS_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.M_AXIS_tready) break;
            guard++;
            if (guard > 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: tready stuck at %b, expected 1", bus.M_AXIS_tready);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.M_AXIS_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.PamMap2AddHead_valid) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Downstream ready: 0 = always ready, 1 = toggle every 4 cycles, 2 = stalled
    initial begin
        int cnt;
        cnt = 0;
        bus.PamMap2AddHead_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            case (ready_mode)
                0:       bus.PamMap2AddHead_ready = 1'b1;
                1:       if (cnt % 4 == 0) bus.PamMap2AddHead_ready = ~bus.PamMap2AddHead_ready;
                default: bus.PamMap2AddHead_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each accepted output beat, and check stalled beats hold
    initial begin
        logic             prev_stall;
        logic [LN*CW-1:0] prev_data;
        logic             prev_last;
        exp_t             e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (arst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (!(bus.PamMap2AddHead_valid === 1'b1 && bus.PamMap2AddHead_data === prev_data &&
                          bus.PamMap2AddHead_last === prev_last)) begin
                        n_err++;
                        $display("FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                                 bus.PamMap2AddHead_valid, bus.PamMap2AddHead_data, bus.PamMap2AddHead_last,
                                 prev_data, prev_last);
                    end
                end
                if (bus.PamMap2AddHead_valid && bus.PamMap2AddHead_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat: got data=%h last=%b, expected no beat",
                                 bus.PamMap2AddHead_data, bus.PamMap2AddHead_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.PamMap2AddHead_data !== e.data || bus.PamMap2AddHead_last !== e.last) begin
                            n_err++;
                            $display("FAIL out_beat: got data=%h last=%b, expected data=%h last=%b",
                                     bus.PamMap2AddHead_data, bus.PamMap2AddHead_last, e.data, e.last);
                        end
                    end
                end
                prev_stall = bus.PamMap2AddHead_valid && !bus.PamMap2AddHead_ready;
                prev_data  = bus.PamMap2AddHead_data;
                prev_last  = bus.PamMap2AddHead_last;
            end
        end
    end

    // Watchdog
    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        n_vec      = 0;
        n_err      = 0;
        ready_mode = 0;
        arst       = 1'b1;
        cfg_bps    = 3'd2;
        cfg_offset = '0;
        cfg_step   = '0;
        bus.M_AXIS_tdata  = '0;
        bus.M_AXIS_tkeep  = '0;
        bus.M_AXIS_tlast  = 1'b0;
        bus.M_AXIS_tvalid = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("reset_init");
        @(posedge clk);
        #1;
        arst = 1'b0;
        #1;
        check("tready_at_release", 32'(bus.M_AXIS_tready), 32'd0);
        @(posedge clk);
        #1;
        check("tready_first_edge", 32'(bus.M_AXIS_tready), 32'd1);

        // PAM4 ramp, single full beat, zero-padded flush
        cfg_bps = 3'd2; cfg_offset = 12'd0; cfg_step = 12'd1365;
        expect_beat(12'd0, 12'd1365, 1'b0);
`ifdef PAM_MAP_GRAY_EN
        expect_beat(12'd4095, 12'd2730, 1'b0);
`else
        expect_beat(12'd2730, 12'd4095, 1'b0);
`endif
        for (int i = 0; i < 6; i++) expect_beat(12'd0, 12'd0, i == 5);
        send_beat(32'h0000_00E4, 4'b1111, 1'b1);
        drain("pam4_ramp");

        // Two kept bytes: exact multiple of the group, no padding beat
        for (int i = 0; i < 4; i++) begin
`ifdef PAM_MAP_GRAY_EN
            expect_beat(12'd2730, 12'd2730, i == 3);
`else
            expect_beat(12'd4095, 12'd4095, i == 3);
`endif
        end
        send_beat(32'h0000_FFFF, 4'b0011, 1'b1);
        drain("partial_keep");

        // Saturation at full scale
        cfg_offset = 12'd4000; cfg_step = 12'd100;
        expect_beat(12'd4095, 12'd4000, 1'b0);
        expect_beat(12'd4000, 12'd4000, 1'b1);
        send_beat(32'h0000_0003, 4'b0001, 1'b1);
        drain("saturation");

        // Zero-keep tlast on an empty buffer: no output at all
        send_beat(32'hDEAD_BEEF, 4'b0000, 1'b1);
        drain("empty_tlast");

        // Zero-keep tlast ending a frame that still holds bits
        cfg_offset = 12'd0; cfg_step = 12'd1365;
`ifdef PAM_MAP_GRAY_EN
        expect_beat(12'd2730, 12'd4095, 1'b0);
`else
        expect_beat(12'd4095, 12'd2730, 1'b0);
`endif
        expect_beat(12'd1365, 12'd0, 1'b1);
        send_beat(32'h0000_001B, 4'b0001, 1'b0);
        send_beat(32'h0000_0000, 4'b0000, 1'b1);
        drain("keep0_tlast");

        // Reset in the middle of a frame with output stalled
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_beat(32'h0000_00A5 + i, 4'b0001, 1'b0);
        #2;
        arst = 1'b1;
        #1;
        check_reset("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_hold");
        arst       = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        cfg_bps = 3'd1; cfg_offset = 12'd500; cfg_step = 12'd300;
        expect_beat(12'd800, 12'd500, 1'b0);
        for (int i = 0; i < 3; i++) expect_beat(12'd500, 12'd500, i == 2);
        send_beat(32'h0000_0001, 4'b0001, 1'b1);
        drain("after_reset");

        // PAM16 stream under periodic backpressure
        ready_mode = 1;
        cfg_bps = 3'd4; cfg_offset = 12'd100; cfg_step = 12'd200;
        for (int i = 0; i < 500; i++) begin
            logic [31:0] w;
            w = 32'h1234_5600 + 32'(i);
            for (int j = 0; j < 4; j++) begin
                expect_beat(ref_code(w[j*8 +: 4], 100, 200),
                            ref_code(w[j*8+4 +: 4], 100, 200),
                            (i == 499) && (j == 3));
            end
            send_beat(w, 4'b1111, i == 499);
        end
        drain("backpressure");
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
